// File: rtl/fu_wb_arbiter_pkg.sv
// Shared FU identifiers and default widths for the write-back path.
// These values are also used by the scoreboard.
package fu_wb_arbiter_pkg;

  localparam int N_FU = 5;
  localparam int DW   = 32;
  localparam int RW   = 5;

  typedef enum logic [2:0] {
    FU_ALU  = 3'd0,
    FU_MEM  = 3'd1,
    FU_MUL  = 3'd2,
    FU_DIV  = 3'd3,
    FU_JUMP = 3'd4
  } fu_id_e;

endpackage

// File: rtl/fu_wb_arbiter_rr_pick.sv
// Rotate-priority picker: the first set request at or after i_ptr wins.
// The search runs in ascending order and wraps from NUM-1 to 0.
module rr_pick
  import fu_wb_arbiter_pkg::*;
#(
  parameter int NUM = N_FU,
  parameter int PW  = $clog2(NUM)
) (
  input  logic [NUM-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic           o_gnt_valid,
  output logic [PW-1:0]  o_gnt_idx
);

  always_comb begin
    logic [PW-1:0] w_idx;
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_idx       = i_ptr;
    for (int k = 0; k < NUM; k++) begin
      if (!o_gnt_valid && i_req[w_idx]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_idx;
      end
      w_idx = (w_idx == PW'(NUM - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: holds one result per functional unit.
// Each cycle it retires one held result to the register file, using round-robin order.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = N_FU,
  parameter int DATA_W = DW,
  parameter int REG_W  = RW,
  parameter int PW     = $clog2(NUM_FU)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_FU-1:0]        i_fu_finish,
  input  logic [NUM_FU*DATA_W-1:0] i_fu_data,
  input  logic [NUM_FU*REG_W-1:0]  i_fu_rd,
  output logic [NUM_FU-1:0]        o_fu_slot_busy,
  output logic                     o_wb_valid,
  output logic                     o_wb_we,
  output logic [REG_W-1:0]         o_wb_rd,
  output logic [DATA_W-1:0]        o_wb_data,
  output logic [PW-1:0]            o_wb_fu,
  output logic                     o_err_overflow
);

  logic [NUM_FU-1:0] r_slot_valid;
  logic [REG_W-1:0]  r_slot_rd   [NUM_FU];
  logic [DATA_W-1:0] r_slot_data [NUM_FU];
  logic [PW-1:0]     r_rr_ptr;

  logic              w_gnt_valid;
  logic [PW-1:0]     w_gnt_idx;
  logic [NUM_FU-1:0] w_gnt_mask;
  logic [NUM_FU-1:0] w_load;
  logic [NUM_FU-1:0] w_ovf;
  logic [REG_W-1:0]  w_in_rd   [NUM_FU];
  logic [DATA_W-1:0] w_in_data [NUM_FU];

  rr_pick #(.NUM(NUM_FU), .PW(PW)) u_pick (
    .i_req       (r_slot_valid),
    .i_ptr       (r_rr_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  always_comb begin
    w_gnt_mask = '0;
    if (w_gnt_valid) w_gnt_mask[w_gnt_idx] = 1'b1;
  end

  // A slot can take a new result only if it is empty or it is being drained this edge.
  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
      assign w_in_rd[gi]   = i_fu_rd[gi*REG_W +: REG_W];
      assign w_in_data[gi] = i_fu_data[gi*DATA_W +: DATA_W];
      assign w_load[gi]    = i_fu_finish[gi] && (!r_slot_valid[gi] || w_gnt_mask[gi]);
      assign w_ovf[gi]     = i_fu_finish[gi] && r_slot_valid[gi] && !w_gnt_mask[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_slot_rd[i]   <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_load[i]) begin
          r_slot_valid[i] <= 1'b1;
          r_slot_rd[i]    <= w_in_rd[i];
          r_slot_data[i]  <= w_in_data[i];
        end else if (w_gnt_mask[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  logic              r_wb_valid;
  logic              r_wb_we;
  logic [REG_W-1:0]  r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [PW-1:0]     r_wb_fu;
  logic              r_err_overflow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_we        <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_wb_fu        <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      r_wb_valid <= w_gnt_valid;
      r_wb_we    <= w_gnt_valid && (r_slot_rd[w_gnt_idx] != '0);
      if (w_gnt_valid) begin
        r_wb_rd   <= r_slot_rd[w_gnt_idx];
        r_wb_data <= r_slot_data[w_gnt_idx];
        r_wb_fu   <= w_gnt_idx;
        r_rr_ptr  <= (w_gnt_idx == PW'(NUM_FU - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (|w_ovf) r_err_overflow <= 1'b1;
    end
  end

  assign o_fu_slot_busy = r_slot_valid;
  assign o_wb_valid     = r_wb_valid;
  assign o_wb_we        = r_wb_we;
  assign o_wb_rd        = r_wb_rd;
  assign o_wb_data      = r_wb_data;
  assign o_wb_fu        = r_wb_fu;
  assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter. It covers capture, round-robin order, rd=0,
// refill and overflow, and asynchronous reset, all against hand-computed values.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    fu_finish = '0;
  logic [159:0]  fu_data = '0;
  logic [24:0]   fu_rd = '0;
  logic [4:0]    fu_slot_busy;
  logic          wb_valid;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [2:0]    wb_fu;
  logic          err_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fu_wb_arbiter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fu_finish    (fu_finish),
    .i_fu_data      (fu_data),
    .i_fu_rd        (fu_rd),
    .o_fu_slot_busy (fu_slot_busy),
    .o_wb_valid     (wb_valid),
    .o_wb_we        (wb_we),
    .o_wb_rd        (wb_rd),
    .o_wb_data      (wb_data),
    .o_wb_fu        (wb_fu),
    .o_err_overflow (err_overflow)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fin(input int i, input logic [4:0] rd, input logic [31:0] d);
    fu_finish[i]        = 1'b1;
    fu_rd[i*5 +: 5]     = rd;
    fu_data[i*32 +: 32] = d;
  endtask

  task automatic retire_chk(input string tag, input int fu, input logic [4:0] rd,
                            input logic [31:0] d);
    check_val({tag, ".valid"}, 64'(wb_valid), 64'd1);
    check_val({tag, ".we"},    64'(wb_we),    64'(rd != 5'd0));
    check_val({tag, ".fu"},    64'(wb_fu),    64'(fu));
    check_val({tag, ".rd"},    64'(wb_rd),    64'(rd));
    check_val({tag, ".data"},  64'(wb_data),  64'(d));
    $display("retire %s fu=%0d rd=%0d data=%08h", tag, wb_fu, wb_rd, wb_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    step();
    check_val("rst.valid", 64'(wb_valid), 64'd0);
    check_val("rst.busy",  64'(fu_slot_busy), 64'd0);
    check_val("rst.err",   64'(err_overflow), 64'd0);
    check_val("rst.data",  64'(wb_data), 64'd0);
    rst = 1'b0;
    step();

    // 1. Single MEM result: busy for one cycle, retires two edges after the finish pulse
    fin(FU_MEM, 5'd7, 32'hDEADBEEF);
    step();
    fu_finish = '0;
    check_val("t1.busy0", 64'(fu_slot_busy), 64'h02);
    check_val("t1.early", 64'(wb_valid), 64'd0);
    step();
    retire_chk("t1", 1, 5'd7, 32'hDEADBEEF);
    check_val("t1.busy1", 64'(fu_slot_busy), 64'h00);
    step();
    check_val("t1.idle", 64'(wb_valid), 64'd0);
    check_val("t1.we_idle", 64'(wb_we), 64'd0);
    check_val("t1.hold_rd", 64'(wb_rd), 64'd7);
    check_val("t1.hold_data", 64'(wb_data), 64'hDEADBEEF);

    // 2. Two full bursts from rr_ptr=0
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 5; i++) fin(i, 5'(i + 1 + 16*b), 32'h1000 + 32'(b*16'h1000) + 32'(i));
      step();
      fu_finish = '0;
      check_val("t2.busy", 64'(fu_slot_busy), 64'h1F);
      for (int k = 0; k < 5; k++) begin
        step();
        retire_chk($sformatf("t2.b%0d.k%0d", b, k), k, 5'(k + 1 + 16*b),
                   32'h1000 + 32'(b*16'h1000) + 32'(k));
      end
      step();
      check_val("t2.drain", 64'(wb_valid), 64'd0);
    end

    // 3. Rotation: FU2 grant moves rr_ptr to 3, so FU4 beats FU0
    fin(FU_MUL, 5'd3, 32'h3000);
    step();
    fu_finish = '0;
    step();
    retire_chk("t3.fu2", 2, 5'd3, 32'h3000);
    fin(FU_ALU, 5'd4, 32'h3100);
    fin(FU_JUMP, 5'd5, 32'h3104);
    step();
    fu_finish = '0;
    check_val("t3.cap", 64'(wb_valid), 64'd0);
    step();
    retire_chk("t3.fu4", 4, 5'd5, 32'h3104);
    step();
    retire_chk("t3.fu0", 0, 5'd4, 32'h3100);

    // 4. rd=0 still retires but does not write
    fin(FU_ALU, 5'd0, 32'd5);
    step();
    fu_finish = '0;
    step();
    retire_chk("t4", 0, 5'd0, 32'd5);

    // 5. Refill on grant, then overflow on a non-granted slot
    fin(FU_MUL, 5'd9, 32'hAAAA0001);
    step();
    fin(FU_MUL, 5'd10, 32'hBBBB0002);
    step();
    fu_finish = '0;
    retire_chk("t5.old", 2, 5'd9, 32'hAAAA0001);
    check_val("t5.refill", 64'(fu_slot_busy), 64'h04);
    check_val("t5.noerr", 64'(err_overflow), 64'd0);
    step();
    retire_chk("t5.new", 2, 5'd10, 32'hBBBB0002);
    fin(FU_MUL, 5'd11, 32'hCCCC0003);
    fin(FU_DIV, 5'd12, 32'hDDDD0004);
    step();
    fu_finish = '0;
    check_val("t5.noerr2", 64'(err_overflow), 64'd0);
    fin(FU_MUL, 5'd13, 32'hEEEE0005);
    step();
    fu_finish = '0;
    retire_chk("t5.fu3", 3, 5'd12, 32'hDDDD0004);
    check_val("t5.err", 64'(err_overflow), 64'd1);
    step();
    retire_chk("t5.kept", 2, 5'd11, 32'hCCCC0003);
    check_val("t5.sticky", 64'(err_overflow), 64'd1);

    // 6. Asynchronous reset between edges with three slots valid
    fin(FU_ALU, 5'd1, 32'h6000);
    fin(FU_MEM, 5'd2, 32'h6001);
    fin(FU_DIV, 5'd3, 32'h6003);
    step();
    fu_finish = '0;
    check_val("t6.busy", 64'(fu_slot_busy), 64'h0B);
    #2 rst = 1'b1;
    #1;
    check_val("t6.busy_rst", 64'(fu_slot_busy), 64'h00);
    check_val("t6.err_rst",  64'(err_overflow), 64'd0);
    check_val("t6.data_rst", 64'(wb_data), 64'd0);
    check_val("t6.rd_rst",   64'(wb_rd), 64'd0);
    check_val("t6.fu_rst",   64'(wb_fu), 64'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val($sformatf("t6.quiet%0d", k), 64'(wb_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
